// File: rtl/mac_pkg.sv
// Shared MAC definitions: transmit-arbiter state encoding and frame-size defaults.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PKT   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_arb_state_e;

  localparam int MAC_MAX_LEN    = 1518;
  localparam int MAC_BYTE_CNT_W = 11;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that adds 0, 1 or 2 per cycle and sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         tx_clk,
  input  logic         rstn,
  input  logic [1:0]   inc,
  output logic [W-1:0] cnt
);

  // Two guard bits so that adding 2 to all-ones is always visible as overflow.
  logic [W+1:0] sum;

  always_comb begin
    sum = {2'b00, cnt} + {{W{1'b0}}, inc};
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge tx_clk) begin
    if (!rstn)                     cnt <= '0;
    else if (sum[W+1:W] != 2'b00)  cnt <= '1;
    else                           cnt <= sum[W-1:0];
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Two-requester round-robin packet arbiter feeding the MAC transmit write port,
// with MAX_LEN truncation, orphan-beat discard and saturating statistics.
module mac_tx_arbiter
  import mac_pkg::*;
#(
  parameter int MAX_LEN = MAC_MAX_LEN,
  parameter int CNT_W   = 8
) (
  input  logic             tx_clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [7:0]       s0_data,
  input  logic             s0_sop,
  input  logic             s0_eop,
  input  logic             s0_err,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [7:0]       s1_data,
  input  logic             s1_sop,
  input  logic             s1_eop,
  input  logic             s1_err,
  input  logic             s1_valid,
  output logic             s1_ready,
  output logic [7:0]       tx_data,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic             tx_err,
  output logic             tx_wren,
  input  logic             tx_rdy,
  output logic             busy,
  output logic             grant,
  output logic [CNT_W-1:0] trunc_cnt,
  output logic [CNT_W-1:0] orphan_cnt
);

  localparam logic [MAC_BYTE_CNT_W-1:0] LAST_IDX = MAC_BYTE_CNT_W'(MAX_LEN - 1);

  tx_arb_state_e             state, state_next;
  logic                      rr_pref;
  logic [MAC_BYTE_CNT_W-1:0] byte_cnt;

  logic [7:0] sel_data;
  logic       sel_sop, sel_eop, sel_err, sel_valid;
  logic       cand0, cand1, win, grant_now, acc, trunc;
  logic [1:0] orphan_inc, trunc_inc;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_data   = grant ? s1_data  : s0_data;
    sel_sop    = grant ? s1_sop   : s0_sop;
    sel_eop    = grant ? s1_eop   : s0_eop;
    sel_err    = grant ? s1_err   : s0_err;
    sel_valid  = grant ? s1_valid : s0_valid;
    cand0      = s0_valid & s0_sop;
    cand1      = s1_valid & s1_sop;
    state_next = state;
    s0_ready   = 1'b0;
    s1_ready   = 1'b0;
    win        = (cand0 & cand1) ? rr_pref : cand1;
    grant_now  = 1'b0;
    acc        = 1'b0;
    trunc      = 1'b0;
    orphan_inc = 2'd0;

    case (state)
      ST_IDLE: begin
        // Only non-sop beats are taken here; they are discarded and counted.
        s0_ready = s0_valid & ~s0_sop;
        s1_ready = s1_valid & ~s1_sop;
        if (en & (cand0 | cand1)) begin
          grant_now  = 1'b1;
          state_next = ST_PKT;
        end
      end
      ST_PKT: begin
        s0_ready = ~grant & tx_rdy;
        s1_ready =  grant & tx_rdy;
        acc      = sel_valid & tx_rdy;
        trunc    = acc & ~sel_eop & (byte_cnt == LAST_IDX);
        if (acc & sel_eop) state_next = ST_IDLE;
        else if (trunc)    state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        s0_ready = ~grant;
        s1_ready =  grant;
        if (sel_valid & sel_eop) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Nothing is accepted while reset is held, so the MAC sees a clean flush.
    if (!rstn) begin
      s0_ready = 1'b0;
      s1_ready = 1'b0;
    end
    if (state == ST_IDLE) orphan_inc = {1'b0, s0_ready} + {1'b0, s1_ready};
  end

  assign trunc_inc = {1'b0, trunc};
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge tx_clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge tx_clk) begin
    if (!rstn) begin
      grant    <= 1'b0;
      rr_pref  <= 1'b0;
      byte_cnt <= '0;
      tx_wren  <= 1'b0;
      tx_data  <= 8'h00;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      tx_wren <= acc;
      if (acc) begin
        tx_data  <= sel_data;
        tx_sop   <= sel_sop;
        tx_eop   <= sel_eop | trunc;
        tx_err   <= sel_err | trunc;
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (grant_now) begin
        grant    <= win;
        rr_pref  <= ~win;
        byte_cnt <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_trunc_cnt (
    .tx_clk (tx_clk),
    .rstn   (rstn),
    .inc    (trunc_inc),
    .cnt    (trunc_cnt)
  );

  sat_counter #(.W(CNT_W)) u_orphan_cnt (
    .tx_clk (tx_clk),
    .rstn   (rstn),
    .inc    (orphan_inc),
    .cnt    (orphan_cnt)
  );

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Scoreboard bench: a default arbiter plus a MAX_LEN=16 / CNT_W=2 instance for
// truncation and saturation; expected beats are queued on acceptance.
module tb_mac_tx_arbiter;

  localparam int SML_MAX = 16;

  typedef struct packed {
    logic [7:0]  data;
    logic        sop;
    logic        eop;
    logic        err;
    logic        r;
    logic [31:0] cyc;
  } item_t;

  logic tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  logic       rstn, en;
  logic       tx_rdy [2];
  // Requester index: 0/1 feed the default instance, 2/3 the small one.
  logic [7:0] sd [4];
  logic       ssop [4], seop [4], serr [4], svld [4], srdy [4];
  logic [7:0] td [2];
  logic       tsop [2], teop [2], terr [2], twren [2], busy [2], grant [2];
  logic [7:0] trunc0, orphan0;
  logic [1:0] trunc1, orphan1;

  item_t q0 [$], q1 [$];
  int    vectors = 0, miscompares = 0, cyc = 0;
  int    out_beats [2], sops [2];
  logic  pkt_req [2];
  logic  rr_chk, exp_rr, tog_chk;

  mac_tx_arbiter u_dut (
    .tx_clk(tx_clk), .rstn(rstn), .en(en),
    .s0_data(sd[0]), .s0_sop(ssop[0]), .s0_eop(seop[0]), .s0_err(serr[0]),
    .s0_valid(svld[0]), .s0_ready(srdy[0]),
    .s1_data(sd[1]), .s1_sop(ssop[1]), .s1_eop(seop[1]), .s1_err(serr[1]),
    .s1_valid(svld[1]), .s1_ready(srdy[1]),
    .tx_data(td[0]), .tx_sop(tsop[0]), .tx_eop(teop[0]), .tx_err(terr[0]),
    .tx_wren(twren[0]), .tx_rdy(tx_rdy[0]), .busy(busy[0]), .grant(grant[0]),
    .trunc_cnt(trunc0), .orphan_cnt(orphan0)
  );

  mac_tx_arbiter #(.MAX_LEN(SML_MAX), .CNT_W(2)) u_small (
    .tx_clk(tx_clk), .rstn(rstn), .en(en),
    .s0_data(sd[2]), .s0_sop(ssop[2]), .s0_eop(seop[2]), .s0_err(serr[2]),
    .s0_valid(svld[2]), .s0_ready(srdy[2]),
    .s1_data(sd[3]), .s1_sop(ssop[3]), .s1_eop(seop[3]), .s1_err(serr[3]),
    .s1_valid(svld[3]), .s1_ready(srdy[3]),
    .tx_data(td[1]), .tx_sop(tsop[1]), .tx_eop(teop[1]), .tx_err(terr[1]),
    .tx_wren(twren[1]), .tx_rdy(tx_rdy[1]), .busy(busy[1]), .grant(grant[1]),
    .trunc_cnt(trunc1), .orphan_cnt(orphan1)
  );

  always @(posedge tx_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic mon_beat(input int k);
    item_t it;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      check("unexpected_wren", 32'(twren[k]), 0);
      return;
    end
    it = (k == 0) ? q0.pop_front() : q1.pop_front();
    check("tx_data",  32'(td[k]),    32'(it.data));
    check("tx_sop",   32'(tsop[k]),  32'(it.sop));
    check("tx_eop",   32'(teop[k]),  32'(it.eop));
    check("tx_err",   32'(terr[k]),  32'(it.err));
    check("grant",    32'(grant[k]), 32'(it.r));
    check("latency",  32'(cyc),      it.cyc);
    out_beats[k]++;
    if (tsop[k]) begin
      pkt_req[k] = td[k][7];
      sops[k]++;
      if (k == 0 && rr_chk) begin
        check("rr_order", 32'(td[k][7]), 32'(exp_rr));
        exp_rr = ~exp_rr;
      end
    end else begin
      check("no_interleave", 32'(td[k][7]), 32'(pkt_req[k]));
    end
  endtask

  always @(negedge tx_clk) begin
    for (int k = 0; k < 2; k++) if (twren[k]) mon_beat(k);
    if (tog_chk && busy[0] && !grant[0])
      check("s0_ready_tracks_tx_rdy", 32'(srdy[0]), 32'(tx_rdy[0]));
  end

  // Drive one beat, wait for the handshake, and queue what the MAC must see.
  task automatic beat(input int r, input logic [7:0] d, input logic sop, input logic eop,
                      input logic err, input bit fwd, input bit tr);
    int    t;
    item_t it;
    sd[r] = d; ssop[r] = sop; seop[r] = eop; serr[r] = err; svld[r] = 1'b1;
    t = 0;
    do begin
      @(negedge tx_clk);
      t++;
    end while (!srdy[r] && t < 3000);
    if (!srdy[r]) begin
      check("handshake_timeout", 32'(srdy[r]), 1);
      return;
    end
    if (fwd) begin
      it.data = d; it.sop = sop; it.eop = eop | tr; it.err = err | tr;
      it.r = r[0]; it.cyc = 32'(cyc + 1);
      if (r < 2) q0.push_back(it);
      else       q1.push_back(it);
    end
    @(posedge tx_clk);
    #1;
  endtask

  // Byte i carries {requester, i}; orphan mode sends non-sop beats only.
  task automatic send_pkt(input int r, input int len, input bit orphan, input bit bad);
    int         ml;
    logic [7:0] d;
    bit         tr;
    ml = (r < 2) ? 1518 : SML_MAX;
    for (int i = 0; i < len; i++) begin
      d  = {r[0], 7'(i)};
      tr = !orphan && (i == ml - 1) && (i != len - 1);
      beat(r, d, !orphan && i == 0, !orphan && i == len - 1, bad && i == 2,
           !orphan && i < ml, tr);
    end
    svld[r] = 1'b0;
    ssop[r] = 1'b0;
    seop[r] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    while (busy[k] && t < 5000) begin
      @(negedge tx_clk);
      t++;
    end
    repeat (2) @(negedge tx_clk);
    check("idle_after_pkt", 32'(busy[k]), 0);
    check("scoreboard_empty", (k == 0) ? q0.size() : q1.size(), 0);
    @(posedge tx_clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge tx_clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    for (int i = 0; i < 4; i++) begin
      sd[i] = 8'h00; ssop[i] = 1'b0; seop[i] = 1'b0; serr[i] = 1'b0; svld[i] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      tx_rdy[k] = 1'b1; out_beats[k] = 0; sops[k] = 0; pkt_req[k] = 1'b0;
    end
    rr_chk = 1'b0; exp_rr = 1'b0; tog_chk = 1'b0;
    en = 1'b1; rstn = 1'b0;
    svld[0] = 1'b1;   // an orphan-looking beat must not be taken during reset

    repeat (3) @(negedge tx_clk);
    check("rst_busy",   32'(busy[0]),  0);
    check("rst_wren",   32'(twren[0]), 0);
    check("rst_data",   32'(td[0]),    0);
    check("rst_eop",    32'(teop[0]),  0);
    check("rst_grant",  32'(grant[0]), 0);
    check("rst_trunc",  32'(trunc0),   0);
    check("rst_orphan", 32'(orphan0),  0);
    check("rst_ready0", 32'(srdy[0]),  0);
    check("rst_ready1", 32'(srdy[1]),  0);
    @(posedge tx_clk);
    #1 rstn = 1'b1; svld[0] = 1'b0;

    // 64-byte packet at full rate
    base = out_beats[0];
    send_pkt(0, 64, 1'b0, 1'b0);
    wait_idle(0);
    check("beats_64", 32'(out_beats[0] - base), 64);

    // Input err forwarded on the beat that carries it
    send_pkt(1, 8, 1'b0, 1'b1);
    wait_idle(0);

    // Continuous contention: grants alternate from 0 after reset
    do_reset();
    rr_chk = 1'b1; exp_rr = 1'b0; base = sops[0];
    fork
      begin repeat (4) send_pkt(0, 5, 1'b0, 1'b0); end
      begin repeat (4) send_pkt(1, 6, 1'b0, 1'b0); end
    join
    wait_idle(0);
    rr_chk = 1'b0;
    check("rr_packets", 32'(sops[0] - base), 8);

    // tx_rdy toggling every cycle
    base = out_beats[0];
    tog_chk = 1'b1;
    fork
      begin send_pkt(0, 32, 1'b0, 1'b0); tog_chk = 1'b0; end
      begin
        while (tog_chk) begin
          @(posedge tx_clk);
          #1 tx_rdy[0] = ~tx_rdy[0];
        end
      end
    join
    tx_rdy[0] = 1'b1;
    wait_idle(0);
    check("beats_toggle", 32'(out_beats[0] - base), 32);

    // en low in IDLE holds off the grant
    en = 1'b0; sd[0] = 8'h00; ssop[0] = 1'b1; svld[0] = 1'b1;
    repeat (4) begin
      @(negedge tx_clk);
      check("en_off_busy",  32'(busy[0]), 0);
      check("en_off_ready", 32'(srdy[0]), 0);
    end
    @(posedge tx_clk);
    #1 en = 1'b1;
    send_pkt(0, 4, 1'b0, 1'b0);
    wait_idle(0);

    // en dropped mid-packet: packet still completes
    base = out_beats[0];
    fork
      send_pkt(0, 10, 1'b0, 1'b0);
      begin repeat (3) @(posedge tx_clk); #1 en = 1'b0; end
    join
    wait_idle(0);
    check("beats_en_drop", 32'(out_beats[0] - base), 10);
    en = 1'b1;

    // Overlapping orphan beats: 3 + 2
    fork
      send_pkt(0, 3, 1'b1, 1'b0);
      begin @(posedge tx_clk); #1; send_pkt(1, 2, 1'b1, 1'b0); end
    join
    @(negedge tx_clk);
    check("orphan_5", 32'(orphan0), 5);
    check("orphan_no_busy", 32'(busy[0]), 0);

    // Small instance: truncation at 16, then exact-16 packet untouched
    base = out_beats[1];
    send_pkt(3, 20, 1'b0, 1'b0);
    wait_idle(1);
    check("trunc_beats", 32'(out_beats[1] - base), 16);
    check("trunc_cnt_1", 32'(trunc1), 1);
    send_pkt(2, 16, 1'b0, 1'b0);
    wait_idle(1);
    check("exact_beats", 32'(out_beats[1] - base), 32);
    check("trunc_cnt_hold", 32'(trunc1), 1);
    fork
      send_pkt(2, 3, 1'b1, 1'b0);
      begin @(posedge tx_clk); #1; send_pkt(3, 2, 1'b1, 1'b0); end
    join
    @(negedge tx_clk);
    check("orphan_sat", 32'(orphan1), 3);

    // Reset while beat 10 is presented
    @(posedge tx_clk);
    #1;
    for (int i = 0; i < 9; i++) beat(0, 8'(i), i == 0, 1'b0, 1'b0, 1'b1, 1'b0);
    sd[0] = 8'd9; ssop[0] = 1'b0; rstn = 1'b0;
    @(posedge tx_clk);
    @(negedge tx_clk);
    check("midrst_wren",   32'(twren[0]), 0);
    check("midrst_busy",   32'(busy[0]),  0);
    check("midrst_ready",  32'(srdy[0]),  0);
    check("midrst_orphan", 32'(orphan0),  0);
    check("midrst_trunc",  32'(trunc1),   0);
    check("midrst_sb",     q0.size(),     0);
    svld[0] = 1'b0;
    @(posedge tx_clk);
    #1 rstn = 1'b1;
    base = out_beats[0];
    send_pkt(0, 6, 1'b0, 1'b0);
    wait_idle(0);
    check("post_rst_beats", 32'(out_beats[0] - base), 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_tx_arbiter.md
MAC_TX_ARBITER -- requirements
Module: mac_tx_arbiter

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1518, meaning the maximum number of bytes per packet forwarded to the MAC.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the saturating statistics counters.
REQ-003 Ports (name, direction, width, meaning); one clock, reset synchronous active-low:
- tx_clk in 1: sole clock; same clock as the MAC transmit interface.
- rstn in 1: synchronous active-low reset.
- en in 1: arbitration enable; a packet in progress always completes.
- s0_data in 8, s0_sop in 1, s0_eop in 1, s0_err in 1, s0_valid in 1: requester 0 byte stream.
- s0_ready out 1: requester 0 beat accepted when s0_valid & s0_ready.
- s1_data, s1_sop, s1_eop, s1_err, s1_valid, s1_ready: same as requester 0, for requester 1.
- tx_data out 8, tx_sop out 1, tx_eop out 1, tx_err out 1, tx_wren out 1: MAC transmit write port.
- tx_rdy in 1: MAC can accept (not almost-full, not in reset).
- busy out 1: high while a packet is granted or draining.
- grant out 1: index of the current or last granted requester.
- trunc_cnt out CNT_W: packets truncated at MAX_LEN.
- orphan_cnt out CNT_W: beats discarded outside a packet.

Function
REQ-004 SHALL implement states IDLE, PKT, DRAIN.
REQ-005 IDLE: a requester with valid & sop is a candidate; grant is decided in IDLE and PKT is entered the next cycle, with no beat accepted in the deciding cycle.
REQ-006 Both requesters are candidates: SHALL grant the requester not granted last (round-robin); after reset the first tie goes to requester 0.
REQ-007 en=0 in IDLE: SHALL not grant; discards per REQ-008 continue.
REQ-008 In IDLE, a requester with valid & ~sop: its ready SHALL be 1; the beat is discarded; orphan_cnt increments.
REQ-009 Both requesters discard in the same cycle: orphan_cnt SHALL increment by 2.
REQ-010 PKT ready: granted ready = tx_rdy; ungranted ready = 0.
REQ-011 Each accepted beat in PKT SHALL appear on tx_* with tx_wren=1 exactly one cycle later; otherwise tx_wren=0 and the tx_* data fields hold.
REQ-012 tx_sop is forwarded as received; a sop mid-packet SHALL be passed unchanged.
REQ-013 An accepted beat with eop=1 in PKT SHALL return the block to IDLE the next cycle.
REQ-014 Byte counter: SHALL be 11 bits; cleared on entry to PKT; incremented per accepted beat.
REQ-015 Beat accepted when count == MAX_LEN-1 without eop: SHALL be output with tx_eop=1, tx_err=1; trunc_cnt increments; next state DRAIN.
REQ-016 The MAX_LEN-th beat carrying eop SHALL be forwarded normally, with no truncation.
REQ-017 DRAIN: granted ready SHALL be 1 regardless of tx_rdy; beats are discarded with tx_wren=0; IDLE follows the accepted eop beat.
REQ-018 tx_err SHALL equal the input err, OR-ed with truncation.
REQ-019 trunc_cnt and orphan_cnt SHALL saturate at all-ones and never wrap.
REQ-020 busy = (state != IDLE).
REQ-021 en deasserted in PKT or DRAIN: SHALL be ignored until return to IDLE.

Reset
REQ-022 rstn=0 at a tx_clk edge SHALL set: state IDLE, grant 0, round-robin pointer to requester 0, byte counter 0, counters 0, tx_wren 0, tx_data/sop/eop/err 0, s0_ready/s1_ready 0.
REQ-023 Reset mid-packet SHALL abandon the packet without emitting eop; rstn is asserted together with the MAC reset so the MAC flushes its FIFO.

Structure
REQ-024 State encoding and the MAX_LEN default SHALL live in the shared MAC package used by the MAC blocks.
REQ-025 SHALL contain one sub-module: sat_counter (parameterised width, increment by 0/1/2, saturating), instantiated twice.
REQ-026 Round-robin, FSM and output register SHALL be flat in mac_tx_arbiter.

Verification
REQ-027 s0 sends a 64-byte packet, tx_rdy=1 -> 64 tx_wren beats, each 1 cycle after acceptance, sop on first, eop on last, err=0, then IDLE.
REQ-028 s0 and s1 both present sop continuously for 4 packets each -> grants alternate 0,1,0,1..., starting with 0 after reset; no interleaving within a packet.
REQ-029 tx_rdy toggles 1/0 every cycle during a packet -> s0_ready tracks tx_rdy; output byte order intact; no beat lost or duplicated.
REQ-030 MAX_LEN=16; s1 sends 20 bytes -> 16 beats out, beat 16 eop=1 err=1; 4 bytes drained with tx_wren=0; trunc_cnt=1.
REQ-031 In IDLE, s0 sends 3 non-sop beats while s1 sends 2 in overlapping cycles -> orphan_cnt=5; CNT_W=2 with 5 orphans -> orphan_cnt=3.
REQ-032 rstn=0 on beat 10 of a packet -> next cycle tx_wren=0, readies 0, busy=0, counters 0; a new s0 packet after release is granted normally.
